// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;
   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_INC = 32'd4;

   typedef enum logic {FETCH, DRAIN} fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & ~32'h3;
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched words; flush empties it in one cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type T = fetch_entry_t
)(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  T                       push_data_i,
   output T                       head_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   T               mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AW:0]    count_q;
   logic           do_push, do_pop;

   assign do_push = push_i && !flush_i && (count_q != (AW+1)'(DEPTH));
   assign do_pop  = pop_i && !flush_i && (count_q != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: reads are only meaningful while count is nonzero.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, issues credit-limited memory requests, queues returned words.
//  state | meaning
//  FETCH | no stale responses in flight; responses are enqueued
//  DRAIN | drop_cnt > 0; responses from before a redirect are discarded
module instr_fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0
)(
   input  logic                   clk_i,
   input  logic                   rst_i,
   output logic                   imem_req_valid_o,
   input  logic                   imem_req_ready_i,
   output logic [31:0]            imem_req_addr_o,
   input  logic                   imem_rsp_valid_i,
   input  logic [31:0]            imem_rsp_instr_i,
   input  logic                   redirect_i,
   input  logic [31:0]            redirect_pc_i,
   output logic                   instr_valid_o,
   input  logic                   instr_ready_i,
   output logic [31:0]            instr_o,
   output logic [31:0]            instr_pc_o,
   output logic [31:0]            instr_pc_plus4_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d, fifo_count;
   logic            req_fire, push, pop, fifo_empty;
   fetch_entry_t    head, push_entry;

   // Queue slots plus words in flight never exceed DEPTH, so a response always has room.
   assign imem_req_valid_o = !rst_i && !redirect_i &&
                             (({1'b0, fifo_count} + {1'b0, outst_q}) < (CW+1)'(DEPTH));
   assign imem_req_addr_o  = fetch_pc_q;
   assign req_fire         = imem_req_valid_o && imem_req_ready_i;
   assign push             = imem_rsp_valid_i && (state_q == FETCH) && !redirect_i;
   assign pop              = instr_valid_o && instr_ready_i && !redirect_i;
   assign push_entry.instr = imem_rsp_instr_i;
   assign push_entry.pc    = rsp_pc_q;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_d     = drop_q;
      state_d    = state_q;
      outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
      if (redirect_i) begin
         fetch_pc_d = align_pc(redirect_pc_i);
         rsp_pc_d   = align_pc(redirect_pc_i);
         drop_d     = outst_d;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + PC_INC;
         if (imem_rsp_valid_i) begin
            if (state_q == DRAIN) drop_d = drop_q - CW'(1);
            else                  rsp_pc_d = rsp_pc_q + PC_INC;
         end
      end
      case (state_q)
         FETCH:   if (drop_d != '0) state_d = DRAIN;
         DRAIN:   if (drop_d == '0) state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .pop_i       (pop),
      .flush_i     (redirect_i),
      .push_data_i (push_entry),
      .head_o      (head),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   // Data outputs read as zero while empty so nothing stale leaks to decode.
   assign instr_valid_o    = !fifo_empty;
   assign instr_o          = instr_valid_o ? head.instr : '0;
   assign instr_pc_o       = instr_valid_o ? head.pc : '0;
   assign instr_pc_plus4_o = instr_valid_o ? head.pc + PC_INC : '0;
   assign count_o          = fifo_count;
endmodule
